// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file write-back arbiter.
// Holds widths, default FIFO depth and the queued write record.
package regfile_wb_arbiter_pkg;

  localparam int AW        = 5;
  localparam int DW        = 32;
  localparam int DEPTH_DEF = 2;

  typedef struct packed {
    logic [AW-1:0] n;
    logic [DW-1:0] d;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Requester, register-file write and hazard-query signals.
// slave: arbiter side; master: pipeline / bench side.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic          v0;
  logic          r0;
  logic [AW-1:0] n0;
  logic [DW-1:0] d0;
  logic          v1;
  logic          r1;
  logic [AW-1:0] n1;
  logic [DW-1:0] d1;
  logic [AW-1:0] wn;
  logic [DW-1:0] d;
  logic          we;
  logic [AW-1:0] rqa;
  logic [AW-1:0] rqb;
  logic          hita;
  logic          hitb;
  logic          busy;

  modport slave (
    input  v0, n0, d0, v1, n1, d1, rqa, rqb,
    output r0, r1, wn, d, we, hita, hitb, busy
  );

  modport master (
    output v0, n0, d0, v1, n1, d1, rqa, rqb,
    input  r0, r1, wn, d, we, hita, hitb, busy
  );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// wb_fifo: DEPTH-entry write-back FIFO, async active-high clr.
// Ports: push/din, pop, full, empty, head, per-entry vld/num.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       push,
  input  wb_entry_t                  din,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output wb_entry_t                  head,
  output logic [DEPTH-1:0]           vld,
  output logic [DEPTH-1:0][AW-1:0]   num
);

  localparam int AB = $clog2(DEPTH);
  localparam int PW = AB + 1;

  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW-1:0] cnt;
  logic          do_push;
  logic          do_pop;
  wb_entry_t     mem [DEPTH];

  // extra pointer bit tells full from empty
  assign empty   = (wp == rp);
  assign full    = (wp[AB] != rp[AB]) &&
                   (wp[AB-1:0] == rp[AB-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rp[AB-1:0]];
  assign cnt     = wp - rp;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AB-1:0]] <= din;
  end

  // slot i is live when its distance from the head is below cnt
  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    logic [AB-1:0] off;
    assign off    = AB'(i) - rp[AB-1:0];
    assign vld[i] = ({1'b0, off} < cnt);
    assign num[i] = mem[i].n;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register-file write port (ALU/load).
// Ports: clk, clr, bus (slave): requests, rf write, hazard query.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input logic                 clk,
  input logic                 clr,
  regfile_wb_arbiter_if.slave bus
);

  logic                     full0;
  logic                     full1;
  logic                     empty0;
  logic                     empty1;
  logic                     g0;
  logic                     g1;
  logic                     last;
  wb_entry_t                in0;
  wb_entry_t                in1;
  wb_entry_t                h0;
  wb_entry_t                h1;
  wb_entry_t                sel;
  logic [DEPTH-1:0]         vld0;
  logic [DEPTH-1:0]         vld1;
  logic [DEPTH-1:0][AW-1:0] num0;
  logic [DEPTH-1:0][AW-1:0] num1;
  logic [AW-1:0]            wn_q;
  logic [DW-1:0]            d_q;
  logic                     we_q;
  logic                     ha;
  logic                     hb;

  assign in0 = {bus.n0, bus.d0};
  assign in1 = {bus.n1, bus.d1};

  wb_fifo #(.DEPTH(DEPTH)) u_f0 (
    .clk   (clk),
    .clr   (clr),
    .push  (bus.v0),
    .din   (in0),
    .pop   (g0),
    .full  (full0),
    .empty (empty0),
    .head  (h0),
    .vld   (vld0),
    .num   (num0)
  );

  wb_fifo #(.DEPTH(DEPTH)) u_f1 (
    .clk   (clk),
    .clr   (clr),
    .push  (bus.v1),
    .din   (in1),
    .pop   (g1),
    .full  (full1),
    .empty (empty1),
    .head  (h1),
    .vld   (vld1),
    .num   (num1)
  );

  // last=1: port 1 was granted last, so port 0 wins a tie
  assign g0  = !empty0 && (empty1 || last);
  assign g1  = !empty1 && (empty0 || !last);
  assign sel = g1 ? h1 : h0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      last <= 1'b1;
      we_q <= 1'b0;
      wn_q <= '0;
      d_q  <= '0;
    end else if (g0 || g1) begin
      last <= g1;
      wn_q <= sel.n;
      d_q  <= sel.d;
      // r0 is hardwired zero: consume, never write
      we_q <= (sel.n != '0);
    end else begin
      we_q <= 1'b0;
    end
  end

  always_comb begin
    ha = we_q && (wn_q == bus.rqa);
    hb = we_q && (wn_q == bus.rqb);
    for (int i = 0; i < DEPTH; i++) begin
      if (vld0[i] && num0[i] == bus.rqa) ha = 1'b1;
      if (vld1[i] && num1[i] == bus.rqa) ha = 1'b1;
      if (vld0[i] && num0[i] == bus.rqb) hb = 1'b1;
      if (vld1[i] && num1[i] == bus.rqb) hb = 1'b1;
    end
    if (bus.rqa == '0) ha = 1'b0;
    if (bus.rqb == '0) hb = 1'b0;
  end

  assign bus.r0   = !full0;
  assign bus.r1   = !full1;
  assign bus.wn   = wn_q;
  assign bus.d    = d_q;
  assign bus.we   = we_q;
  assign bus.hita = ha;
  assign bus.hitb = hb;
  assign bus.busy = !empty0 || !empty1 || we_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (wn/d/we) between two write-back requesters: port 0 (ALU result) and port 1 (load/memory result). Each port has a small FIFO. A round-robin arbiter drains one entry per cycle into a registered write stage that drives the register file directly. Pending-write query ports report when a read would see stale data, so the pipeline can stall on that hazard.

Parameters:
DEPTH, 2, entries per port FIFO; power of 2, minimum 2
AW, 5, register-number width
DW, 32, data width

Ports:
clk  in  1  clock; all state updates on the rising edge
clr  in  1  asynchronous active-high reset
v0  in  1  port 0 write request valid
r0  out  1  port 0 ready (FIFO not full)
n0  in  AW  port 0 destination register
d0  in  DW  port 0 write data
v1  in  1  port 1 write request valid
r1  out  1  port 1 ready
n1  in  AW  port 1 destination register
d1  in  DW  port 1 write data
wn  out  AW  register-file write register number
d  out  DW  register-file write data
we  out  1  register-file write enable
rqa  in  AW  query register A (the read-port A register number)
rqb  in  AW  query register B
hita  out  1  a write to rqa is still pending
hitb  out  1  a write to rqb is still pending
busy  out  1  any FIFO is non-empty or we=1

Behaviour:
- Reset (clr=1, async): both FIFOs emptied, all pointers 0, last_grant=1 (port 0 wins the first tie), we=0, wn=0, d=0. Asserting clr mid-operation discards buffered writes; no partial write is issued.
- Push: an entry is accepted on an edge where vX=1 and rX=1. rX = !fullX. rX is computed from the current occupancy only, so a full FIFO refuses a push even in a cycle when it pops.
- Each FIFO keeps strict order within its port. Pointer width is log2(DEPTH)+1; the extra bit separates full from empty; pointers wrap modulo 2*DEPTH.
- Arbitration, combinational on the FIFO heads each cycle:
  - both non-empty: grant the port != last_grant;
  - one non-empty: grant that port;
  - neither: no grant.
  - On a grant: pop the head, set last_grant to the granted port.
- Fairness: a waiting head loses at most one consecutive grant.
- Output stage, registered, updated every edge:
  - on a grant: wn <= head.n, d <= head.d, we <= (head.n != 0);
  - with no grant: we <= 0, while wn and d hold their values.
  - A request to r0 is consumed but never drives we=1.
- Latency:
  - push at edge N into an empty FIFO, port uncontested;
  - head visible during cycle N+1;
  - we=1 during cycle N+2 (after edge N+1);
  - the register file captures the write at edge N+2.
- Simultaneous push and pop on the same FIFO (not full) is legal; occupancy is unchanged.
- Both ports targeting the same register in the same cycle: writes occur in grant order, so the later grant wins in the register file. Neither write is dropped.
- Hazard query: hita=1 iff rqa != 0 AND rqa matches any of:
  - a valid entry in either FIFO;
  - the output stage (we=1 && wn==rqa).
  hitb follows the same rule for rqb. Both are purely combinational from the current state and do not include same-cycle pushes.
- busy = !empty0 | !empty1 | we.

Decomposition:
- Shared package: AW and DW constants, DEPTH default, and a wb_entry record {n[AW], d[DW]}.
- One natural sub-module: wb_fifo (DEPTH-entry synchronous FIFO with async active-high clr). It exposes push, pop, full, empty and head, plus a per-entry valid/number vector for the hazard match. Instantiate it twice.
- Arbiter, output stage and hazard compare live in the top module.

Test Plan:
1. Reset: assert clr mid-stream with both FIFOs holding 2 entries -> immediately we=0, busy=0, r0=r1=1; nothing is written after clr is released.
2. Single write: push v0 with n0=5, d0=0x1234 at edge N -> we=1, wn=5, d=0x1234 during cycle N+2 only; hita=1 for rqa=5 from cycle N+1 through N+2.
3. Contention: both ports push every cycle, 4 entries each, n0=1..4, n1=11..14 -> we sequence is 1,11,2,12,3,13,4,14 with no gaps; r0 and r1 drop to 0 once their FIFO holds DEPTH entries.
4. r0 filter: push n1=0, d1=0xFFFF -> popped in the expected cycle with we=0; a following push n1=3 is written one cycle later; hitb=0 for rqb=0 throughout.
5. Same-register collision: at one edge push n0=7, d0=0xA and n1=7, d1=0xB, with last_grant=1 -> 0xA written first, then 0xB; hita for rqa=7 stays 1 until the cycle after the second we.
6. Full boundary: fill port 0 (DEPTH=2) while port 1 is granted -> r0=0; when v0 is held high, no entry is lost and none is duplicated; popped data order equals push order.
